// File: rtl/dmem_pkg.sv
// Types and sizing helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_t;

  // Default geometry: 32-bit words, 1024 words.
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_STRB_W = DMEM_DATA_W / 8;
  localparam int DMEM_DEPTH  = 1024;
  localparam int DMEM_IDX_W  = $clog2(DMEM_DEPTH);

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int dmem_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wait-counter width: it must hold LATENCY-2 (at least one bit).
  function automatic int dmem_cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency - 1) : 1;
  endfunction

endpackage

// File: rtl/lsu_pkg.sv
// Load/store interface types shared between the LSU and the data-memory side.
// The request and response structs are fixed at a 32-bit datapath.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_STRB_W = LSU_DATA_W / 8;

  typedef struct packed {
    logic                  read_en;
    logic                  write_en;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
    logic [LSU_STRB_W-1:0] strb;
  } lsu_to_mem_s;

  typedef struct packed {
    logic [LSU_DATA_W-1:0] data;
    logic                  r_success;
    logic                  w_success;
  } mem_to_lsu_s;

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
// Contents have no reset.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane writes: only lanes with their enable set are updated.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (we_i[i]) begin
        mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one LSU request at a time, answers it
// LATENCY cycles after acceptance with a single-cycle success pulse.
// Optional macro DMEM_ACCESS_ERR_EN adds err_o (out-of-range or read+write).
//
// Handshake: a request (read_en or write_en high) is taken only in IDLE.
// The latched copy is used until the one-cycle RESP pulse, after which the
// FSM is back in IDLE; a request still held then is a new transaction.
// DATA_WIDTH/ADDR_WIDTH must match the lsu_pkg struct field widths.
module dmem_responder
  import lsu_pkg::*;
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  lsu_to_mem_s lsu_to_mem_i,
  output mem_to_lsu_s mem_to_lsu_o
`ifdef DMEM_ACCESS_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = dmem_idx_width(DEPTH);
  localparam int CNT_W  = dmem_cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  dmem_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dmem_op_t              op_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
`ifdef DMEM_ACCESS_ERR_EN
  logic                  both_q;
`endif

  logic                  req_any;
  logic                  accept;
  logic                  req_oor;
  logic [STRB_W-1:0]     ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr_lsbs;

  assign req_any = lsu_to_mem_i.read_en | lsu_to_mem_i.write_en;
  assign accept  = (state_q == IDLE) & req_any;
  // Any address bit above the word index makes the access out of range.
  assign req_oor = |lsu_to_mem_i.addr[ADDR_WIDTH-1:IDX_W+2];
  // Byte offset is the requester's concern; lane selection is via strb.
  assign unused_addr_lsbs = ^lsu_to_mem_i.addr[1:0];

  // State register and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch: captured on acceptance, held through WAIT and RESP.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q    <= lsu_to_mem_i.write_en ? OP_WRITE : OP_READ;
      idx_q   <= lsu_to_mem_i.addr[IDX_W+1:2];
      oor_q   <= req_oor;
      wdata_q <= lsu_to_mem_i.data;
      strb_q  <= lsu_to_mem_i.strb;
`ifdef DMEM_ACCESS_ERR_EN
      both_q  <= lsu_to_mem_i.read_en & lsu_to_mem_i.write_en;
`endif
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is zero except in the single RESP cycle.
  always_comb begin
    mem_to_lsu_o = '0;
    ram_we       = '0;
`ifdef DMEM_ACCESS_ERR_EN
    err_o        = 1'b0;
`endif
    if (state_q == RESP) begin
      if (op_q == OP_READ) begin
        mem_to_lsu_o.r_success = 1'b1;
        mem_to_lsu_o.data      = oor_q ? '0 : ram_rdata;
      end else begin
        mem_to_lsu_o.w_success = 1'b1;
        // A reset on the edge ending RESP aborts the commit.
        if (!oor_q && !rst_i) begin
          ram_we = strb_q;
        end
      end
`ifdef DMEM_ACCESS_ERR_EN
      err_o = oor_q | both_q;
`endif
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .idx_i   (idx_q),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) driven with
// directed requests; expected responses with their due cycle go into
// per-instance queues and a negedge monitor compares every cycle.
module tb_dmem_responder;
  import lsu_pkg::*;

  localparam int EW = 66;  // {is_wr, err, data[31:0], due_cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, rst4;
  lsu_to_mem_s req1, req3, req4;
  mem_to_lsu_s rsp1, rsp3, rsp4;
  logic err1, err3, err4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  logic [EW-1:0] exp_q4[$];

  dmem_responder #(.LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst1), .lsu_to_mem_i(req1), .mem_to_lsu_o(rsp1)
`ifdef DMEM_ACCESS_ERR_EN
    , .err_o(err1)
`endif
  );
  dmem_responder #(.LATENCY(3)) u3 (
    .clk_i(clk), .rst_i(rst3), .lsu_to_mem_i(req3), .mem_to_lsu_o(rsp3)
`ifdef DMEM_ACCESS_ERR_EN
    , .err_o(err3)
`endif
  );
  dmem_responder #(.LATENCY(4)) u4 (
    .clk_i(clk), .rst_i(rst4), .lsu_to_mem_i(req4), .mem_to_lsu_o(rsp4)
`ifdef DMEM_ACCESS_ERR_EN
    , .err_o(err4)
`endif
  );

`ifndef DMEM_ACCESS_ERR_EN
  assign err1 = 1'b0;
  assign err3 = 1'b0;
  assign err4 = 1'b0;
`endif

  // ---------------- queue helpers ----------------
  function automatic int qsize(input int d);
    case (d)
      1:       return exp_q1.size();
      3:       return exp_q3.size();
      default: return exp_q4.size();
    endcase
  endfunction

  function automatic logic [EW-1:0] qfront(input int d);
    case (d)
      1:       return exp_q1[0];
      3:       return exp_q3[0];
      default: return exp_q4[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      1:       void'(exp_q1.pop_front());
      3:       void'(exp_q3.pop_front());
      default: void'(exp_q4.pop_front());
    endcase
  endtask

  task automatic qpush(input int d, input logic [EW-1:0] e);
    case (d)
      1:       exp_q1.push_back(e);
      3:       exp_q3.push_back(e);
      default: exp_q4.push_back(e);
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input lsu_to_mem_s rq);
    case (d)
      1:       req1 = rq;
      3:       req3 = rq;
      default: req4 = rq;
    endcase
  endtask

  function automatic int lat_of(input int d);
    return (d == 1) ? 1 : (d == 3) ? 3 : 4;
  endfunction

  // One request, held for exactly the accept edge, then wait for completion.
  task automatic issue(input int d, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] xdata,
                       input logic xerr);
    lsu_to_mem_s rq;
    int lat;
    lat = lat_of(d);
    rq.read_en  = rd;
    rq.write_en = wr;
    rq.addr     = addr;
    rq.data     = wdata;
    rq.strb     = strb;
    @(posedge clk); #1;
    drive(d, rq);
    qpush(d, {wr, xerr, xdata, 32'(cyc + lat)});
    @(posedge clk); #1;
    drive(d, '0);
    repeat (lat) @(posedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check(input int d, input mem_to_lsu_s r, input logic e);
    logic [EW-1:0] ent;
    logic have, fired, x_wr, x_err;
    logic [31:0] x_data;
    int due;
    fired = r.r_success | r.w_success;
    have  = 1'b0;
    ent   = '0;
    if (qsize(d) > 0) begin
      ent  = qfront(d);
      have = 1'b1;
    end
    x_wr   = ent[65];
    x_err  = ent[64];
    x_data = ent[63:32];
    due    = int'(ent[31:0]);
    if (fired) begin
      total++;
      if (!have || due != cyc) begin
        bad++;
        $display("FAIL dut%0d unexpected_resp cyc=%0d got r=%b w=%b data=%h, required no response (next due %0d)",
                 d, cyc, r.r_success, r.w_success, r.data, have ? due : -1);
      end else begin
        qpop(d);
        if (r.r_success !== !x_wr || r.w_success !== x_wr || r.data !== x_data) begin
          bad++;
          $display("FAIL dut%0d resp cyc=%0d got r=%b w=%b data=%h, required r=%b w=%b data=%h",
                   d, cyc, r.r_success, r.w_success, r.data, !x_wr, x_wr, x_data);
        end
`ifdef DMEM_ACCESS_ERR_EN
        total++;
        if (e !== x_err) begin
          bad++;
          $display("FAIL dut%0d err cyc=%0d got %b, required %b", d, cyc, e, x_err);
        end
`endif
      end
    end else begin
      total++;
      if (r.data !== '0
`ifdef DMEM_ACCESS_ERR_EN
          || e !== 1'b0
`endif
         ) begin
        bad++;
        $display("FAIL dut%0d idle_zero cyc=%0d got data=%h err=%b, required 0", d, cyc, r.data, e);
      end
      if (have && due == cyc) begin
        total++;
        bad++;
        $display("FAIL dut%0d missing_resp cyc=%0d got none, required %s data=%h",
                 d, cyc, x_wr ? "w_success" : "r_success", x_data);
        qpop(d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(1, rsp1, err1);
      check(3, rsp3, err3);
      check(4, rsp4, err4);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    lsu_to_mem_s rq;
    int e;
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    req1 = '0;   req3 = '0;   req4 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // LATENCY=1: word write then read, sub-word offset ignored
    issue(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // byte strobe into lane 2
    issue(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 32'h22, 32'h00AA0000, 4'h4, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11AA3344, 1'b0);

    // zero strobe write: success, RAM unchanged
    issue(1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11AA3344, 1'b0);

    // read+write together: write wins, err flagged
    issue(1, 1'b1, 1'b1, 32'h40, 32'h55667788, 4'hF, 32'h0, 1'b1);
    issue(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h55667788, 1'b0);

    // out of range: write discarded (no alias onto word 0), read gives 0
    issue(1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 32'h1000, 32'h0BADBEEF, 4'hF, 32'h0, 1'b1);
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);

    // read held continuously: accepted every other cycle
    rq = '0;
    rq.read_en = 1'b1;
    rq.addr    = 32'h10;
    @(posedge clk); #1;
    req1 = rq;
    e = cyc + 1;
    qpush(1, {1'b0, 1'b0, 32'hDEADBEEF, 32'(e)});
    qpush(1, {1'b0, 1'b0, 32'hDEADBEEF, 32'(e + 2)});
    qpush(1, {1'b0, 1'b0, 32'hDEADBEEF, 32'(e + 4)});
    repeat (5) @(posedge clk);
    #1;
    req1 = '0;
    repeat (3) @(posedge clk);

    // LATENCY=4: response exactly 4 cycles after accept, zeros between
    issue(4, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issue(4, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // LATENCY=3: reset in WAIT aborts the write, no w_success
    issue(3, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0);
    rq = '0;
    rq.write_en = 1'b1;
    rq.addr     = 32'h30;
    rq.data     = 32'hCAFEF00D;
    rq.strb     = 4'hF;
    @(posedge clk); #1;
    req3 = rq;
    @(posedge clk); #1;
    req3 = '0;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    repeat (4) @(posedge clk);
    issue(3, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b0);

    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      if (d == 1 || d == 3 || d == 4) begin
        total++;
        if (qsize(d) != 0) begin
          bad++;
          $display("FAIL dut%0d drain got %0d pending, required 0", d, qsize(d));
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the memory side of the load/store interface.
- Accepts `lsu_to_mem_s` requests (`read_en`, `write_en`, `addr`, `data`, `strb`) and holds a word-organised RAM with byte-strobe writes.
- Returns `mem_to_lsu_s` (`data`, `r_success`, `w_success`) after a configurable latency, so the core's memory stage sees realistic multi-cycle memory behaviour.

Parameters:
- `DATA_WIDTH`, 32, word width in bits; `strb` width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32, byte-address width of the request.
- `DEPTH`, 1024, number of words in the RAM.
- `LATENCY`, 1, cycles from accept to success pulse; minimum 1.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `lsu_to_mem_i`  input  `lsu_to_mem_s`  request from the LSU: `read_en`, `write_en`, `addr`, `data`, `strb`.
- `mem_to_lsu_o`  output  `mem_to_lsu_s`  response to the LSU: `data`, `r_success`, `w_success`.

Behaviour:
- Reset values:
  - state = IDLE, wait counter = 0.
  - All `mem_to_lsu_o` fields are 0.
  - RAM contents are NOT cleared by reset.
- Word index is `addr[$clog2(DEPTH)+1:2]`; `addr[1:0]` is ignored. Lane alignment is the requester's job via `strb`/`data`.
- State IDLE:
  - If `write_en` or `read_en` is high, latch `addr`, `data`, `strb` and op type.
  - If both are high, a write is latched and no read occurs.
  - Go to RESP if `LATENCY==1`, else to WAIT with counter = `LATENCY-2`.
- State WAIT: decrement the counter; go to RESP when the counter is 0. Request inputs are ignored (the latched copy is used).
- State RESP (exactly one cycle), then unconditionally IDLE:
  - Read: `mem_to_lsu_o.data` = RAM[latched index], `r_success`=1.
  - Write: `w_success`=1, `data`=0. RAM bytes with `strb[i]=1` are updated at the edge ending RESP; other bytes are unchanged.
- Latency: a request sampled in IDLE at edge T gives success in the cycle after edge T+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance.
- Back-to-back requests:
  - Any request still high in the IDLE cycle after RESP is accepted as a new transaction.
  - The requester must drop or advance its request in the cycle after it sees success.
- `data`, `r_success` and `w_success` are 0 in every non-RESP cycle.
- Read-after-write to the same word: the following transaction observes the written value, because the write commits before IDLE.
- Out-of-range: if any `addr` bits above the index are nonzero:
  - a write is discarded;
  - a read returns 0;
  - success is still pulsed.
- Reset during WAIT or RESP: return to IDLE with no success pulse. A pending write is aborted and the RAM is unmodified.
- `strb`=0 with `write_en`: a full transaction with `w_success`, and no RAM change.

Optional Feature:
- Macro: `DMEM_ACCESS_ERR_EN`.
- Defined:
  - Adds port `err_o` (output, 1 bit, reset 0).
  - `err_o` pulses in the RESP cycle when the transaction was out-of-range, or had both `read_en` and `write_en` high at accept.
  - Success flags still pulse alongside `err_o`.
- Undefined: no `err_o` port; these cases are handled silently as above.

Decomposition:
- `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - localparams for strobe width and index width;
  - an op enum {OP_READ, OP_WRITE}.
- Request/response structs are reused from `lsu_pkg`; they are not redefined.
- One sub-module, `dmem_array`:
  - inputs: clock, index, byte-strobe write enable, write data;
  - output: asynchronous read data.
  - `dmem_responder` holds the FSM, counter and latches.

Test Plan:
- Word write/read, `LATENCY`=1: write `addr`=0x10, `data`=0xDEADBEEF, `strb`=0xF → `w_success` 1 cycle after accept. Then read 0x10 → `r_success` with `data`=0xDEADBEEF.
- Byte strobe: word 0x20 = 0x11223344. Write `addr`=0x22, `data`=0x00AA0000, `strb`=0x4, then read 0x20 → 0x11AA3344.
- Latency: `LATENCY`=4, read 0x10 → `r_success` exactly 4 cycles after accept. Flags and data are 0 in the 3 intervening cycles.
- Reset mid-op: `LATENCY`=3, write 0x30 = 0xCAFEF00D with `rst_i` high in the WAIT cycle. Then read 0x30 → the old value, and no `w_success` was seen.
- Back-to-back and conflict:
  - Read held continuously with `LATENCY`=1 → `r_success` every other cycle.
  - `read_en`=`write_en`=1 → write performed, only `w_success`.
  - `err_o`=1 when `DMEM_ACCESS_ERR_EN` is defined.
- Out-of-range, `DEPTH`=1024: write `addr`=0x1000 → `w_success`, and a read of 0x0 is unchanged. Read `addr`=0x1000 → `data` 0 and `r_success`; `err_o`=1 when the feature is enabled.
